seq_magnitude_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator: the successor to the fixed 16-bit ripple comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, scanning from the MSB chunk down to the LSB chunk.
- Optionally stops early at the first differing chunk; supports signed and unsigned compares per operation.
- Sits beside the ALU/branch unit with valid/ready handshakes on both sides, so wide compares do not create a long ripple path.

---
 rtl/seq_magnitude_comparator.sv | 137 +++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans WIDTH-bit operands CHUNK bits per cycle, MSB chunk first,
// with optional early exit at the first differing chunk and per-operation signed/unsigned mode.
module seq_magnitude_comparator #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHUNK      = 4,
  parameter int unsigned EARLY_EXIT = 1,
  localparam int unsigned NCHUNK    = WIDTH / CHUNK,
  localparam int unsigned CW        = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [CW-1:0]    out_chunks
);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hit_q, hit_d, hlt_q, hlt_d, hgt_q, hgt_d;
  logic             lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
  logic [CW-1:0]    chunks_q, chunks_d;

  logic [CHUNK-1:0] ca, cb;
  logic             cur_diff, last, res_hit, res_lt, res_gt;

  // Operands shift left each cycle so the chunk under test is always the top CHUNK bits.
  assign ca = a_q[WIDTH-1 -: CHUNK];
  assign cb = b_q[WIDTH-1 -: CHUNK];

  always_comb begin
    cur_diff = (ca != cb);
    last     = (cnt_q == CW'(NCHUNK - 1));
    res_hit  = hit_q | cur_diff;
    // Once a difference is recorded, lower chunks cannot override it.
    res_lt   = hit_q ? hlt_q : (ca < cb);
    res_gt   = hit_q ? hgt_q : (ca > cb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      hlt_q    <= 1'b0;
      hgt_q    <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      chunks_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      hlt_q    <= hlt_d;
      hgt_q    <= hgt_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      chunks_q <= chunks_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    hlt_d    = hlt_q;
    hgt_d    = hgt_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    chunks_d = chunks_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Flipping the sign bits turns a two's-complement compare into an unsigned one.
          a_d            = inp1;
          b_d            = inp2;
          a_d[WIDTH-1]   = inp1[WIDTH-1] ^ is_signed;
          b_d[WIDTH-1]   = inp2[WIDTH-1] ^ is_signed;
          cnt_d          = '0;
          hit_d          = 1'b0;
          hlt_d          = 1'b0;
          hgt_d          = 1'b0;
          state_d        = CMP;
        end
      end
      CMP: begin
        a_d   = a_q << CHUNK;
        b_d   = b_q << CHUNK;
        cnt_d = cnt_q + 1'b1;
        hit_d = res_hit;
        hlt_d = res_lt;
        hgt_d = res_gt;
        if (((EARLY_EXIT != 0) && cur_diff) || last) begin
          lt_d     = res_lt;
          gt_d     = res_gt;
          eq_d     = ~res_hit;
          chunks_d = cnt_q + 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign lt         = lt_q;
  assign gt         = gt_q;
  assign eq         = eq_q;
  assign out_chunks = chunks_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator: instance 0 uses early exit, instance 1 scans all chunks.
module tb_seq_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid, in_ready, is_signed, out_valid, out_ready, lt, gt, eq;
  logic [15:0] inp1 [2];
  logic [15:0] inp2 [2];
  logic [2:0]  out_chunks [2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) dut_ee (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .inp1(inp1[0]), .inp2(inp2[0]), .is_signed(is_signed[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .lt(lt[0]), .gt(gt[0]), .eq(eq[0]), .out_chunks(out_chunks[0])
  );

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .inp1(inp1[1]), .inp2(inp2[1]), .is_signed(is_signed[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .lt(lt[1]), .gt(gt[1]), .eq(eq[1]), .out_chunks(out_chunks[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after the accepting edge T.
  task automatic send(input int sel, input logic [15:0] a, input logic [15:0] b, input logic s);
    int n = 0;
    while (!in_ready[sel] && n < 20) begin tick(); n++; end
    inp1[sel] = a; inp2[sel] = b; is_signed[sel] = s; in_valid[sel] = 1'b1;
    tick();
    in_valid[sel] = 1'b0;
  endtask

  // Edges after T until out_valid is seen (k); first edge sampling it high is then T+k+1.
  task automatic wait_valid(input int sel, output int n);
    n = 0;
    while (!out_valid[sel] && n < 20) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; out_ready = 2'b11; is_signed = '0;
    inp1[0] = '0; inp2[0] = '0; inp1[1] = '0; inp2[1] = '0;
    tick(); tick();
    checks++; if (in_ready !== 2'b11) begin errors++; $display("FAIL rst_in_ready got %b expected 11", in_ready); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL rst_out_valid got %b expected 00", out_valid); end
    checks++; if ({lt, gt, eq} !== 6'b0) begin errors++; $display("FAIL rst_flags got %b expected 000000", {lt, gt, eq}); end
    checks++; if (out_chunks[0] !== 3'd0) begin errors++; $display("FAIL rst_chunks got %0d expected 0", out_chunks[0]); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_equal();
    int n;
    send(0, 16'h1234, 16'h1234, 1'b0);
    wait_valid(0, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL eq_latency got %0d expected 4", n); end
    checks++; if ({lt[0], gt[0], eq[0]} !== 3'b001) begin errors++; $display("FAIL eq_flags got %b expected 001", {lt[0], gt[0], eq[0]}); end
    checks++; if (out_chunks[0] !== 3'd4) begin errors++; $display("FAIL eq_chunks got %0d expected 4", out_chunks[0]); end
    tick();
    checks++; if ({out_valid[0], in_ready[0]} !== 2'b01) begin errors++; $display("FAIL eq_consume got %b expected 01", {out_valid[0], in_ready[0]}); end
    checks++; if ({lt[0], gt[0], eq[0]} !== 3'b001) begin errors++; $display("FAIL eq_hold got %b expected 001", {lt[0], gt[0], eq[0]}); end
  endtask

  task automatic test_signed_top();
    int n;
    send(0, 16'h8000, 16'h7FFF, 1'b0);
    wait_valid(0, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL uns_latency got %0d expected 1", n); end
    checks++; if ({lt[0], gt[0], eq[0]} !== 3'b010) begin errors++; $display("FAIL uns_flags got %b expected 010", {lt[0], gt[0], eq[0]}); end
    checks++; if (out_chunks[0] !== 3'd1) begin errors++; $display("FAIL uns_chunks got %0d expected 1", out_chunks[0]); end
    tick();
    send(0, 16'h8000, 16'h7FFF, 1'b1);
    wait_valid(0, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL sgn_latency got %0d expected 1", n); end
    checks++; if ({lt[0], gt[0], eq[0]} !== 3'b100) begin errors++; $display("FAIL sgn_flags got %b expected 100", {lt[0], gt[0], eq[0]}); end
    checks++; if (out_chunks[0] !== 3'd1) begin errors++; $display("FAIL sgn_chunks got %0d expected 1", out_chunks[0]); end
    tick();
  endtask

  task automatic test_lsb_chunk();
    int n;
    send(0, 16'h12F4, 16'h12F5, 1'b0);
    inp1[0] = 16'hFFFF; inp2[0] = 16'h0000; is_signed[0] = 1'b1;
    wait_valid(0, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL lsb_latency got %0d expected 4", n); end
    checks++; if ({lt[0], gt[0], eq[0]} !== 3'b100) begin errors++; $display("FAIL lsb_flags got %b expected 100", {lt[0], gt[0], eq[0]}); end
    checks++; if (out_chunks[0] !== 3'd4) begin errors++; $display("FAIL lsb_chunks got %0d expected 4", out_chunks[0]); end
    tick();
  endtask

  task automatic test_no_early_exit();
    int n;
    send(1, 16'h9000, 16'h1000, 1'b0);
    wait_valid(1, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL full_latency got %0d expected 4", n); end
    checks++; if ({lt[1], gt[1], eq[1]} !== 3'b010) begin errors++; $display("FAIL full_flags got %b expected 010", {lt[1], gt[1], eq[1]}); end
    checks++; if (out_chunks[1] !== 3'd4) begin errors++; $display("FAIL full_chunks got %0d expected 4", out_chunks[1]); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready[0] = 1'b0;
    send(0, 16'h0003, 16'h0002, 1'b0);
    wait_valid(0, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_latency got %0d expected 4", n); end
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = 1'b1; inp1[0] = 16'h0001; inp2[0] = 16'hF000;
      tick();
      checks++; if ({out_valid[0], in_ready[0]} !== 2'b10) begin errors++; $display("FAIL bp_hs cycle %0d got %b expected 10", i, {out_valid[0], in_ready[0]}); end
      checks++; if ({lt[0], gt[0], eq[0], out_chunks[0]} !== 6'b010100) begin errors++; $display("FAIL bp_hold cycle %0d got %b expected 010100", i, {lt[0], gt[0], eq[0], out_chunks[0]}); end
    end
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    tick();
    checks++; if ({out_valid[0], in_ready[0]} !== 2'b01) begin errors++; $display("FAIL bp_release got %b expected 01", {out_valid[0], in_ready[0]}); end
    send(0, 16'hFFFF, 16'h0001, 1'b1);
    wait_valid(0, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL b2b_latency got %0d expected 1", n); end
    checks++; if ({lt[0], gt[0], eq[0]} !== 3'b100) begin errors++; $display("FAIL b2b_flags got %b expected 100", {lt[0], gt[0], eq[0]}); end
    checks++; if (out_chunks[0] !== 3'd1) begin errors++; $display("FAIL b2b_chunks got %0d expected 1", out_chunks[0]); end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    send(0, 16'h0000, 16'h0001, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({out_valid[0], in_ready[0]} !== 2'b01) begin errors++; $display("FAIL rmid_hs got %b expected 01", {out_valid[0], in_ready[0]}); end
    checks++; if ({lt[0], gt[0], eq[0]} !== 3'b000) begin errors++; $display("FAIL rmid_flags got %b expected 000", {lt[0], gt[0], eq[0]}); end
    checks++; if (out_chunks[0] !== 3'd0) begin errors++; $display("FAIL rmid_chunks got %0d expected 0", out_chunks[0]); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | out_valid[0];
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_result got %b expected 0", seen); end
    send(0, 16'h0005, 16'h0005, 1'b0);
    wait_valid(0, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL rpost_latency got %0d expected 4", n); end
    checks++; if ({lt[0], gt[0], eq[0], out_chunks[0]} !== 6'b001100) begin errors++; $display("FAIL rpost_result got %b expected 001100", {lt[0], gt[0], eq[0], out_chunks[0]}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_equal();
    test_signed_top();
    test_lsb_chunk();
    test_no_early_exit();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
